depacketizer_adder: RTL
=======================

# depacketizer_adder

Receive-side counterpart of the adder's outbound packet format. It accepts 35-bit NoC packets addressed to this node, checks the header, and unpacks the three 8-bit membrane values and three spike bits into a serial valid/ready stream, one neuron per beat, for the downstream neuron/memory stage. Misaddressed or malformed packets are dropped and counted. It is a single-packet-buffered unpacker and sits between the NoC router port and the consumer.

## Interface
- WIDTH_PACKET, 35, packet width.
- WIDTH, 8, membrane value width.
- NUM, 3, neurons per packet.
- MY_ADDR, 3'b100, this node's NoC address.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pkt_in  input  WIDTH_PACKET  packet from NoC.
- pkt_valid  input  1  pkt_in valid.
- pkt_ready  output  1  block accepts pkt_in this cycle.
- mem_out  output  WIDTH  membrane value of current neuron.
- spike_out  output  1  spike bit of current neuron.
- idx_out  output  2  neuron index, 0..NUM-1.
- src_out  output  3  source address of the packet being emitted.
- last_out  output  1  current beat is idx NUM-1.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat.
- drop_cnt  output  8  saturating count of dropped packets.
- busy  output  1  a packet is held (state EMIT).

## Operation
- Packet format: [34:32] dest, [31:29] src, [28:27] reserved (must be 0), [24+i] spike of neuron i, [8*i +: 8] membrane of neuron i, for i = 0..2.
- States: IDLE, EMIT. Index register idx (2 bits), packet hold register, src register.
- IDLE: pkt_ready = 1, out_valid = 0. On pkt_valid & pkt_ready:
  - dest == MY_ADDR and reserved == 2'b00: latch the packet and src, idx <= 0, go to EMIT.
  - otherwise: discard, drop_cnt <= drop_cnt + 1 (saturates at 255), stay in IDLE.
- EMIT: out_valid = 1; mem_out/spike_out selected from the held packet at idx; idx_out = idx; last_out = (idx == NUM-1); src_out = held src.
  - out_ready & !last: idx <= idx + 1.
  - out_ready & last: if pkt_valid in the same cycle, pkt_ready = 1 and the new packet is handled exactly as in IDLE (a good packet loads with idx <= 0 and the state stays EMIT; a bad one is dropped and the state goes to IDLE); if pkt_valid is low, go to IDLE.
  - out_ready low: hold all outputs stable; pkt_ready = 0.
- pkt_ready = !reset & (state == IDLE | (state == EMIT & last & out_ready)). It is combinational from out_ready only on the last beat.
- Beat order is always idx 0, 1, 2. No beat is ever skipped or repeated.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE, idx 0, out_valid 0, pkt_ready 0 while reset is high, mem_out 0, spike_out 0, idx_out 0, src_out 0, last_out 0, drop_cnt 0, busy 0, hold register 0.
- First cycle after reset deasserts: pkt_ready = 1.
- Latency: a packet accepted at edge N gives out_valid = 1 with idx 0 in the cycle after edge N.
- Throughput: NUM beats per packet with no bubble between back-to-back packets. Sustained rate is 1 beat/cycle when out_ready is held high.
- A dropped packet costs 1 cycle and produces no output beat.
- Reset asserted mid-EMIT: the held packet is discarded, and out_valid falls asynchronously.
- Handshake rule: out_valid never drops without out_ready, and output data never changes while out_valid & !out_ready.

## Test plan
- Reset: assert reset with traffic present -> all outputs 0, pkt_ready 0; deassert -> pkt_ready 1 on the next cycle, out_valid 0.
- Good packet: dest 100, src 010, spikes 3'b101, membranes 0x33/0x22/0x11 (idx 2/1/0), out_ready = 1 -> beats (0x11,1,idx0), (0x22,0,idx1), (0x33,1,idx2,last), src_out 010 on each, on consecutive cycles; then IDLE.
- Backpressure: out_ready low for 5 cycles at idx1 -> mem_out 0x22, spike_out 0, idx_out 1 stable, pkt_ready 0 throughout; the beat completes when out_ready rises.
- Drops: dest 011 -> no out_valid, drop_cnt 1; reserved 2'b01 with good dest -> drop_cnt 2; 300 bad packets -> drop_cnt saturates at 255.
- Back-to-back: second good packet (membranes 0xA0/0xB0/0xC0) presented during the last beat of the first -> accepted on that edge; idx0 = 0xA0 on the next cycle, with no idle cycle.
- Reset mid-packet: reset at idx1 -> out_valid 0 immediately; after release, a new packet emits from idx0 with the new data and none of the old data.

Source files
------------

// File: rtl/depacketizer_adder_if.sv
// Bundles the NoC packet input, the serial neuron stream output and the
// status outputs of depacketizer_adder.
interface depacketizer_adder_if #(
  parameter int WIDTH_PACKET = 35,
  parameter int WIDTH        = 8
);
  logic [WIDTH_PACKET-1:0] pkt_in;
  logic                    pkt_valid;
  logic                    pkt_ready;
  logic [WIDTH-1:0]        mem_out;
  logic                    spike_out;
  logic [1:0]              idx_out;
  logic [2:0]              src_out;
  logic                    last_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              drop_cnt;
  logic                    busy;

  // Producer/consumer side: drives packets and accepts beats.
  modport master (
    output pkt_in, pkt_valid, out_ready,
    input  pkt_ready, mem_out, spike_out, idx_out, src_out,
    input  last_out, out_valid, drop_cnt, busy
  );

  // Depacketizer side.
  modport slave (
    input  pkt_in, pkt_valid, out_ready,
    output pkt_ready, mem_out, spike_out, idx_out, src_out,
    output last_out, out_valid, drop_cnt, busy
  );
endinterface

// File: rtl/depacketizer_adder.sv
// Single-packet-buffered NoC depacketizer: checks the header of packets
// addressed to this node and unpacks NUM membrane/spike pairs into a
// valid/ready stream, one neuron per beat. Bad packets are dropped and counted.
//
// state | meaning
// IDLE  | no packet held, ready for a new one
// EMIT  | packet held, streaming beats idx 0..NUM-1
module depacketizer_adder #(
  parameter int         WIDTH_PACKET = 35,
  parameter int         WIDTH        = 8,
  parameter int         NUM          = 3,
  parameter logic [2:0] MY_ADDR      = 3'b100
) (
  input  logic                clk,
  input  logic                reset,
  depacketizer_adder_if.slave bus
);

  localparam int         PAYLOAD  = NUM*WIDTH + NUM;
  localparam logic [1:0] LAST_IDX = 2'(NUM-1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [PAYLOAD-1:0] hold_q, hold_d;
  logic [2:0]         src_q, src_d;
  logic [7:0]         drop_q, drop_d;

  logic             emit;
  logic             last;
  logic             pkt_ready;
  logic             take;
  logic             pkt_good;
  logic [WIDTH-1:0] mem_sel;
  logic             spike_sel;

  assign emit      = (state_q == EMIT);
  assign last      = emit && (idx_q == LAST_IDX);
  // Ready again during the final beat so back-to-back packets leave no bubble.
  assign pkt_ready = !reset && (!emit || (last && bus.out_ready));
  assign take      = bus.pkt_valid && pkt_ready;
  assign pkt_good  = (bus.pkt_in[WIDTH_PACKET-1 -: 3] == MY_ADDR) &&
                     (bus.pkt_in[WIDTH_PACKET-7 -: 2] == 2'b00);

  // Next-state: advance idx, load/drop packets, return to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    src_d   = src_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          if (pkt_good) begin
            hold_d  = bus.pkt_in[PAYLOAD-1:0];
            src_d   = bus.pkt_in[WIDTH_PACKET-4 -: 3];
            idx_d   = 2'd0;
            state_d = EMIT;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (!last) begin
            idx_d = idx_q + 2'd1;
          end else if (take) begin
            if (pkt_good) begin
              hold_d  = bus.pkt_in[PAYLOAD-1:0];
              src_d   = bus.pkt_in[WIDTH_PACKET-4 -: 3];
              idx_d   = 2'd0;
              state_d = EMIT;
            end else begin
              if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the membrane value and spike bit of the current neuron.
  always_comb begin
    mem_sel   = '0;
    spike_sel = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (idx_q == 2'(i)) begin
        mem_sel   = hold_q[i*WIDTH +: WIDTH];
        spike_sel = hold_q[NUM*WIDTH + i];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      src_q   <= 3'd0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      src_q   <= src_d;
      drop_q  <= drop_d;
    end
  end

  // Beat fields are forced to zero outside EMIT so idle outputs are quiet.
  assign bus.pkt_ready = pkt_ready;
  assign bus.out_valid = emit;
  assign bus.mem_out   = emit ? mem_sel : '0;
  assign bus.spike_out = emit && spike_sel;
  assign bus.idx_out   = emit ? idx_q : 2'd0;
  assign bus.src_out   = emit ? src_q : 3'd0;
  assign bus.last_out  = last;
  assign bus.busy      = emit;
  assign bus.drop_cnt  = drop_q;

endmodule
